s2_collect: RTL and testbench
=============================

S2_COLLECT -- requirements
Module: s2_collect

Interface
REQ-001 The module SHALL have parameter ALLOW_OVERWRITE, default 0, meaning that 1 lets a repeated slot write replace the stored bit and 0 rejects it.
REQ-002 CLK  input  1  the single clock; all state SHALL update on the rising edge.
REQ-003 CLR  input  1  asynchronous active-low reset.
REQ-004 DIN  input  1  serial data bit to be stored.
REQ-005 DIN_VALID  input  1  DIN and the select inputs are valid this cycle.
REQ-006 A1, B1, A0, B0  input  1 each  slot-select terms.
REQ-007 WORD_ACK  input  1  consumer has taken the assembled word.
REQ-008 Q  output  4  assembled word, with Q[n] holding the bit for slot n.
REQ-009 FILL  output  4  fill mask, with FILL[n]=1 when slot n has been written in the current word.
REQ-010 WORD_VALID  output  1  all four slots are filled and Q is stable.
REQ-011 OVERRUN  output  1  one-cycle pulse when a DIN_VALID is rejected because WORD_VALID is high.
REQ-012 DUP_ERR  output  1  one-cycle pulse when a write is rejected because its slot is already filled and ALLOW_OVERWRITE=0.

Function
REQ-013 Slot index SHALL be {A1|B1, A0&B0}, decoded as 2 bits: 00=slot0, 01=slot1, 10=slot2, 11=slot3.
REQ-014 Accept condition: DIN_VALID=1 and WORD_VALID=0; on acceptance Q[slot] and FILL[slot] SHALL be set at that edge to DIN and 1 respectively.
REQ-015 Repeated slot with ALLOW_OVERWRITE=1: Q[slot] SHALL take DIN, and FILL SHALL be unchanged.
REQ-016 Repeated slot with ALLOW_OVERWRITE=0: Q and FILL SHALL be unchanged, and DUP_ERR SHALL be 1 for the following cycle.
REQ-017 WORD_VALID SHALL rise at the same edge at which the next FILL value becomes 4'b1111, with zero added latency after the final accepted bit.
REQ-018 While WORD_VALID=1 with no WORD_ACK: DIN_VALID=1 SHALL leave Q and FILL unchanged and SHALL cause OVERRUN=1 for the following cycle, once per rejected cycle.
REQ-019 WORD_ACK=1 while WORD_VALID=1 SHALL clear WORD_VALID and FILL at that edge, and Q SHALL hold its value.
REQ-020 WORD_ACK and DIN_VALID both 1 while WORD_VALID=1: the ack SHALL take effect, the bit SHALL be accepted into a fresh word (FILL becomes one-hot at slot, Q[slot]=DIN), and no OVERRUN SHALL be raised.
REQ-021 WORD_ACK while WORD_VALID=0 SHALL be ignored.
REQ-022 OVERRUN and DUP_ERR SHALL be registered, SHALL last one cycle, and SHALL NOT be sticky.
REQ-023 Input bits SHALL be accepted at full rate of one per cycle, giving a minimum of 4 cycles per word.

Reset
REQ-024 CLR=0 SHALL immediately force Q=4'b0000, FILL=4'b0000, WORD_VALID=0, OVERRUN=0 and DUP_ERR=0, independent of CLK.
REQ-025 Reset asserted in mid-word SHALL discard the partial word; after release, the next accepted bit SHALL start a new word.
REQ-026 The first edge after CLR deasserts SHALL be able to accept data.

Structure
REQ-027 A shared package SHALL hold the slot encoding constants SLOT0..SLOT3 and FILL_FULL=4'b1111.
REQ-028 A single sub-module, s2_slot_dec, SHALL be used: combinational, mapping A1, B1, A0, B0 to a 2-bit index and a 4-bit one-hot enable.
REQ-029 All other logic, including storage, fill mask and flag registers, SHALL stay in s2_collect.

Verification
REQ-030 Fill in order: after reset, write DIN=1,0,1,1 to slots 0,1,2,3 on consecutive cycles (A1B1A0B0 = 0000, 0011, 1000, 1011) -> Q=4'b1101, WORD_VALID=1 after the 4th edge, FILL=4'b1111.
REQ-031 Overrun: with WORD_VALID=1, assert DIN_VALID for 2 cycles without ack -> OVERRUN pulses twice, Q stays 4'b1101.
REQ-032 Simultaneous ack and data: with WORD_VALID=1, assert WORD_ACK together with DIN=0 at slot2 -> WORD_VALID=0, FILL=4'b0100, Q=4'b1001, OVERRUN=0.
REQ-033 Duplicate with ALLOW_OVERWRITE=0: write slot1 with 1, then slot1 with 0 -> Q[1]=1, DUP_ERR=1 for one cycle. Duplicate with ALLOW_OVERWRITE=1: the same sequence -> Q[1]=0, DUP_ERR=0.
REQ-034 Mid-word reset: fill slots 0 and 3, pulse CLR=0 between clock edges -> all outputs 0 immediately; 4 new writes then yield WORD_VALID after exactly 4 accepted bits.

Source files
------------

// File: rtl/s2_collect_pkg.sv
// Shared constants for the s2_collect serial word assembler.
// Slot encodings, the full fill mask and a one-hot helper live here.
package s2_collect_pkg;

  localparam logic [1:0] SLOT0     = 2'd0;
  localparam logic [1:0] SLOT1     = 2'd1;
  localparam logic [1:0] SLOT2     = 2'd2;
  localparam logic [1:0] SLOT3     = 2'd3;
  localparam logic [3:0] FILL_FULL = 4'b1111;

  function automatic logic [3:0] slot_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'b0000;
    case (idx)
      SLOT0:   oh = 4'b0001;
      SLOT1:   oh = 4'b0010;
      SLOT2:   oh = 4'b0100;
      default: oh = 4'b1000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/s2_slot_dec.sv
// Combinational slot decoder: the high index bit comes from A1|B1 and the low bit from A0&B0.
// It produces both the binary slot index and its one-hot write enable.
module s2_slot_dec
  import s2_collect_pkg::*;
(
  input  logic       a1_i,
  input  logic       b1_i,
  input  logic       a0_i,
  input  logic       b0_i,
  output logic [1:0] slot_idx_o,
  output logic [3:0] slot_en_o
);

  always_comb begin
    slot_idx_o = {a1_i | b1_i, a0_i & b0_i};
    slot_en_o  = slot_onehot(slot_idx_o);
  end

endmodule

// File: rtl/s2_collect.sv
// Collects four serial bits into slot-addressed word Q, raising WORD_VALID once every slot is filled.
// Flags the rejected writes: OVERRUN while a word is pending, and DUP_ERR for a repeated slot.
module s2_collect
  import s2_collect_pkg::*;
#(
  parameter bit ALLOW_OVERWRITE = 1'b0
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       DIN,
  input  logic       DIN_VALID,
  input  logic       A1,
  input  logic       B1,
  input  logic       A0,
  input  logic       B0,
  input  logic       WORD_ACK,
  output logic [3:0] Q,
  output logic [3:0] FILL,
  output logic       WORD_VALID,
  output logic       OVERRUN,
  output logic       DUP_ERR
);

  logic [1:0] slot_idx;
  logic [3:0] slot_en;

  logic [3:0] q_q, q_d;
  logic [3:0] fill_q, fill_d;
  logic       wv_q, wv_d;
  logic       overrun_q, overrun_d;
  logic       dup_q, dup_d;

  logic [3:0] fill_base;
  logic       accept;
  logic       slot_taken;

  s2_slot_dec u_dec (
    .a1_i       (A1),
    .b1_i       (B1),
    .a0_i       (A0),
    .b0_i       (B0),
    .slot_idx_o (slot_idx),
    .slot_en_o  (slot_en)
  );

  // An ack on a pending word starts a fresh word in the same cycle, so a
  // simultaneous data bit lands in an empty fill mask instead of overrunning.
  always_comb begin
    fill_base  = (wv_q && WORD_ACK) ? 4'b0000 : fill_q;
    accept     = DIN_VALID && (!wv_q || WORD_ACK);
    slot_taken = fill_base[slot_idx];

    q_d       = q_q;
    fill_d    = fill_base;
    dup_d     = 1'b0;
    overrun_d = DIN_VALID && wv_q && !WORD_ACK;

    if (accept) begin
      if (!slot_taken || ALLOW_OVERWRITE) begin
        q_d = (q_q & ~slot_en) | (slot_en & {4{DIN}});
      end
      fill_d = fill_base | slot_en;
      dup_d  = slot_taken && !ALLOW_OVERWRITE;
    end

    wv_d = (fill_d == FILL_FULL);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      q_q       <= 4'b0000;
      fill_q    <= 4'b0000;
      wv_q      <= 1'b0;
      overrun_q <= 1'b0;
      dup_q     <= 1'b0;
    end else begin
      q_q       <= q_d;
      fill_q    <= fill_d;
      wv_q      <= wv_d;
      overrun_q <= overrun_d;
      dup_q     <= dup_d;
    end
  end

  assign Q          = q_q;
  assign FILL       = fill_q;
  assign WORD_VALID = wv_q;
  assign OVERRUN    = overrun_q;
  assign DUP_ERR    = dup_q;

endmodule

// File: tb/tb_s2_collect.sv
// Self-checking bench for s2_collect: one instance per ALLOW_OVERWRITE setting, both driven
// identically and compared every cycle against a slot/array reference model.
module tb_s2_collect;

  logic CLK;
  logic CLR;
  logic DIN;
  logic DIN_VALID;
  logic A1, B1, A0, B0;
  logic WORD_ACK;

  logic [3:0] q0, fill0, q1, fill1;
  logic       wv0, ovr0, dup0, wv1, ovr1, dup1;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state, one entry per instance (index = ALLOW_OVERWRITE).
  bit mBits   [2][4];
  bit mFilled [2][4];
  bit mValid  [2];
  bit mOver   [2];
  bit mDup    [2];

  s2_collect #(.ALLOW_OVERWRITE(1'b0)) dut0 (
    .CLK(CLK), .CLR(CLR), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .A1(A1), .B1(B1), .A0(A0), .B0(B0), .WORD_ACK(WORD_ACK),
    .Q(q0), .FILL(fill0), .WORD_VALID(wv0), .OVERRUN(ovr0), .DUP_ERR(dup0)
  );

  s2_collect #(.ALLOW_OVERWRITE(1'b1)) dut1 (
    .CLK(CLK), .CLR(CLR), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .A1(A1), .B1(B1), .A0(A0), .B0(B0), .WORD_ACK(WORD_ACK),
    .Q(q1), .FILL(fill1), .WORD_VALID(wv1), .OVERRUN(ovr1), .DUP_ERR(dup1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s observed=%b expected=%b at t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 4; n++) begin
        mBits[d][n]   = 1'b0;
        mFilled[d][n] = 1'b0;
      end
      mValid[d] = 1'b0;
      mOver[d]  = 1'b0;
      mDup[d]   = 1'b0;
    end
  endtask

  // Applies one clock of the word-assembly rules to the model.
  task automatic modelStep(input bit dv, input bit din, input bit a1, input bit b1,
                           input bit a0, input bit b0, input bit ack);
    int  slot;
    int  count;
    bit  writeOk;
    slot = ((a1 | b1) ? 2 : 0) + ((a0 & b0) ? 1 : 0);
    for (int d = 0; d < 2; d++) begin
      mOver[d] = 1'b0;
      mDup[d]  = 1'b0;
      writeOk  = dv;
      if (mValid[d]) begin
        if (ack) begin
          for (int n = 0; n < 4; n++) mFilled[d][n] = 1'b0;
          mValid[d] = 1'b0;
        end else if (dv) begin
          mOver[d] = 1'b1;
          writeOk  = 1'b0;
        end
      end
      if (writeOk) begin
        if (!mFilled[d][slot]) begin
          mBits[d][slot]   = din;
          mFilled[d][slot] = 1'b1;
        end else if (d == 1) begin
          mBits[d][slot] = din;
        end else begin
          mDup[d] = 1'b1;
        end
      end
      count = 0;
      for (int n = 0; n < 4; n++) count += mFilled[d][n];
      mValid[d] = (count == 4);
    end
  endtask

  task automatic compareAll(input string tag);
    logic [3:0] eq, ef;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 4; n++) begin
        eq[n] = mBits[d][n];
        ef[n] = mFilled[d][n];
      end
      checkOutput($sformatf("%s.dut%0d.Q", tag, d),          (d == 0) ? q0 : q1,                  eq);
      checkOutput($sformatf("%s.dut%0d.FILL", tag, d),       (d == 0) ? fill0 : fill1,            ef);
      checkOutput($sformatf("%s.dut%0d.WORD_VALID", tag, d), {3'b000, (d == 0) ? wv0 : wv1},      {3'b000, mValid[d]});
      checkOutput($sformatf("%s.dut%0d.OVERRUN", tag, d),    {3'b000, (d == 0) ? ovr0 : ovr1},    {3'b000, mOver[d]});
      checkOutput($sformatf("%s.dut%0d.DUP_ERR", tag, d),    {3'b000, (d == 0) ? dup0 : dup1},    {3'b000, mDup[d]});
    end
  endtask

  // Called just after a falling edge: drive inputs, clock once, then check at the next falling edge.
  task automatic applyStimulus(input string tag, input bit dv, input bit din, input bit a1, input bit b1,
                               input bit a0, input bit b0, input bit ack);
    DIN_VALID = dv;
    DIN       = din;
    A1 = a1; B1 = b1; A0 = a0; B0 = b0;
    WORD_ACK  = ack;
    modelStep(dv, din, a1, b1, a0, b0, ack);
    @(posedge CLK);
    @(negedge CLK);
    compareAll(tag);
  endtask

  task automatic writeSlot(input string tag, input int slot, input bit din, input bit ack);
    bit hi, lo;
    hi = (slot >= 2);
    lo = (slot % 2) == 1;
    applyStimulus(tag, 1'b1, din, hi, 1'b0, lo, lo, ack);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset pulse between clock edges, checked before the next edge arrives.
  task automatic pulseReset(input string tag);
    #1 CLR = 1'b0;
    modelReset();
    #1;
    compareAll(tag);
    checkOutput({tag, ".allzero"}, q0 | fill0 | q1 | fill1 | {3'b000, wv0 | wv1 | ovr0 | ovr1 | dup0 | dup1}, 4'b0000);
    #1 CLR = 1'b1;
  endtask

  initial begin
    bit dv, din, a1, b1, a0, b0, ack;

    CLR = 1'b0;
    DIN = 1'b0; DIN_VALID = 1'b0; WORD_ACK = 1'b0;
    A1 = 1'b0; B1 = 1'b0; A0 = 1'b0; B0 = 1'b0;
    modelReset();
    #2;
    compareAll("reset");
    @(negedge CLK);
    CLR = 1'b1;

    // Fill in order, first edge after reset release accepts data.
    writeSlot("fill0", 0, 1'b1, 1'b0);
    writeSlot("fill1", 1, 1'b0, 1'b0);
    writeSlot("fill2", 2, 1'b1, 1'b0);
    checkOutput("fill.notyet", {3'b000, wv0}, 4'b0000);
    writeSlot("fill3", 3, 1'b1, 1'b0);
    checkOutput("fill.Q", q0, 4'b1101);
    checkOutput("fill.FILL", fill0, 4'b1111);
    checkOutput("fill.WV", {3'b000, wv0}, 4'b0001);

    // Two rejected writes while the word is pending.
    writeSlot("ovr1", 0, 1'b0, 1'b0);
    checkOutput("ovr1.pulse", {3'b000, ovr0}, 4'b0001);
    writeSlot("ovr2", 1, 1'b1, 1'b0);
    checkOutput("ovr2.pulse", {3'b000, ovr0}, 4'b0001);
    checkOutput("ovr2.Q", q0, 4'b1101);
    idle("ovr.end");
    checkOutput("ovr.notsticky", {3'b000, ovr0}, 4'b0000);

    // Ack together with a new bit starts a fresh word.
    writeSlot("ackdata", 2, 1'b0, 1'b1);
    checkOutput("ackdata.Q", q0, 4'b1001);
    checkOutput("ackdata.FILL", fill0, 4'b0100);
    checkOutput("ackdata.OVR", {3'b000, ovr0}, 4'b0000);
    applyStimulus("ack.ignored", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Duplicate slot behaviour for both overwrite settings.
    pulseReset("dupreset");
    writeSlot("dup.first", 1, 1'b1, 1'b0);
    writeSlot("dup.second", 1, 1'b0, 1'b0);
    checkOutput("dup.dut0.Q1", {3'b000, q0[1]}, 4'b0001);
    checkOutput("dup.dut0.err", {3'b000, dup0}, 4'b0001);
    checkOutput("dup.dut1.Q1", {3'b000, q1[1]}, 4'b0000);
    checkOutput("dup.dut1.err", {3'b000, dup1}, 4'b0000);
    idle("dup.end");

    // Mid-word reset discards the partial word.
    pulseReset("mid.pre");
    writeSlot("mid.s0", 0, 1'b1, 1'b0);
    writeSlot("mid.s3", 3, 1'b1, 1'b0);
    pulseReset("mid.reset");
    writeSlot("mid.n0", 3, 1'b0, 1'b0);
    writeSlot("mid.n1", 2, 1'b1, 1'b0);
    writeSlot("mid.n2", 1, 1'b0, 1'b0);
    checkOutput("mid.after3", {3'b000, wv0}, 4'b0000);
    writeSlot("mid.n3", 0, 1'b1, 1'b0);
    checkOutput("mid.after4", {3'b000, wv0}, 4'b0001);
    checkOutput("mid.Q", q0, 4'b0101);

    // Randomized traffic with occasional acks and resets.
    for (int i = 0; i < 600; i++) begin
      dv  = ($urandom_range(0, 3) != 0);
      din = $urandom_range(0, 1);
      a1  = $urandom_range(0, 1);
      b1  = $urandom_range(0, 1);
      a0  = $urandom_range(0, 1);
      b0  = $urandom_range(0, 1);
      ack = ($urandom_range(0, 2) == 0);
      applyStimulus($sformatf("rand%0d", i), dv, din, a1, b1, a0, b0, ack);
      if ($urandom_range(0, 79) == 0) pulseReset($sformatf("rand%0d.reset", i));
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
